// File: rtl/credit_sender_if.sv
// Handshake bundle between a credit sender and its neighbours.
// The push_* group runs from upstream to the sender.
// The pop_* group runs between the sender and the credit receiver.
// The slave modport is the sender's view; master is the environment's view.
interface credit_sender_if #(
    parameter int WIDTH = 8
);
    logic             push_valid;
    logic             push_ready;
    logic [WIDTH-1:0] push_data;

    logic             pop_valid;
    logic [WIDTH-1:0] pop_data;
    logic             pop_credit;
    logic             pop_sender_in_reset;
    logic             pop_receiver_in_reset;

    modport slave (
        input  push_valid,
        input  push_data,
        output push_ready,
        output pop_valid,
        output pop_data,
        input  pop_credit,
        output pop_sender_in_reset,
        input  pop_receiver_in_reset
    );

    modport master (
        output push_valid,
        output push_data,
        input  push_ready,
        input  pop_valid,
        input  pop_data,
        output pop_credit,
        input  pop_sender_in_reset,
        output pop_receiver_in_reset
    );
endinterface

// File: rtl/credit_sender.sv
// Credit-based flit sender.
// Flits are forwarded only while spendable credits remain. Each send spends
// one credit, and each credit the receiver returns adds one. Returning a
// credit into a full counter sets a sticky overflow flag.
// Optional build macro CREDIT_SENDER_REG_OUT_EN registers pop_valid/pop_data.
// Without the macro the flit passes through combinationally.
// rst is asynchronous and active-low.
module credit_sender #(
    parameter  int WIDTH       = 8,
    parameter  int MAX_CREDITS = 4,
    localparam int CW          = $clog2(MAX_CREDITS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    credit_sender_if.slave     bus,
    input  logic [CW-1:0]      credit_withhold,
    output logic [CW-1:0]      credit_count,
    output logic [CW-1:0]      credit_available,
    output logic               credit_overflow
);

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_CREDITS);
    localparam logic [CW-1:0] ONE     = CW'(1);

    logic [CW-1:0] credit_count_q,  credit_count_d;
    logic          credit_overflow_q, credit_overflow_d;
    logic          sender_in_reset_q, sender_in_reset_d;
    logic [CW-1:0] credit_available_d;
    logic          push_ready_d;
    logic          send;
    logic          credit_in;

    // Spendable credits: count minus reserve, floored at zero.
    always_comb begin
        credit_available_d = '0;
        if (credit_count_q > credit_withhold) begin
            credit_available_d = credit_count_q - credit_withhold;
        end
    end

    // Ready depends on state and receiver reset only, never on push_valid.
    always_comb begin
        push_ready_d = (credit_available_d != '0)
                     && !sender_in_reset_q
                     && !bus.pop_receiver_in_reset;
        send      = bus.push_valid && push_ready_d;
        credit_in = bus.pop_credit && !sender_in_reset_q
                                   && !bus.pop_receiver_in_reset;
    end

    // Next counter, overflow and sender-reset state.
    always_comb begin
        credit_count_d    = credit_count_q;
        credit_overflow_d = credit_overflow_q;
        sender_in_reset_d = 1'b0;
        if (bus.pop_receiver_in_reset) begin
            credit_count_d = '0;
        end else if (send && !credit_in) begin
            credit_count_d = credit_count_q - ONE;
        end else if (credit_in && !send) begin
            if (credit_count_q == MAX_CNT) begin
                credit_overflow_d = 1'b1;
            end else begin
                credit_count_d = credit_count_q + ONE;
            end
        end
    end

    // Credit state registers; sender-reset flag is set asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_count_q    <= '0;
            credit_overflow_q <= 1'b0;
            sender_in_reset_q <= 1'b1;
        end else begin
            credit_count_q    <= credit_count_d;
            credit_overflow_q <= credit_overflow_d;
            sender_in_reset_q <= sender_in_reset_d;
        end
    end

`ifdef CREDIT_SENDER_REG_OUT_EN
    logic             pop_valid_q, pop_valid_d;
    logic [WIDTH-1:0] pop_data_q,  pop_data_d;

    // Capture the flit on a send; hold the data otherwise.
    always_comb begin
        pop_valid_d = send;
        pop_data_d  = pop_data_q;
        if (send) begin
            pop_data_d = bus.push_data;
        end
    end

    // Output registers; reset discards any pending flit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
        end else begin
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
        end
    end

    // Drive the registered flit toward the receiver.
    always_comb begin
        bus.pop_valid = pop_valid_q;
        bus.pop_data  = pop_data_q;
    end
`else
    // Zero-latency pass-through of the accepted flit.
    always_comb begin
        bus.pop_valid = send;
        bus.pop_data  = bus.push_data;
    end
`endif

    // Status outputs.
    always_comb begin
        bus.push_ready          = push_ready_d;
        bus.pop_sender_in_reset = sender_in_reset_q;
        credit_count            = credit_count_q;
        credit_available        = credit_available_d;
        credit_overflow         = credit_overflow_q;
    end

endmodule

// File: tb/tb_credit_sender.sv
// Directed self-checking bench for credit_sender (WIDTH 8, MAX_CREDITS 4).
// Covers both output builds through CREDIT_SENDER_REG_OUT_EN.
module tb_credit_sender;

    localparam int WIDTH = 8;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [CW-1:0] credit_withhold = '0;
    logic [CW-1:0] credit_count;
    logic [CW-1:0] credit_available;
    logic          credit_overflow;

    int n_tests = 0;
    int n_fail  = 0;

    credit_sender_if #(.WIDTH(WIDTH)) bus ();

    credit_sender #(.WIDTH(WIDTH), .MAX_CREDITS(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .credit_withhold  (credit_withhold),
        .credit_count     (credit_count),
        .credit_available (credit_available),
        .credit_overflow  (credit_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.push_valid            = 1'b1;
        bus.push_data             = 8'h77;
        bus.pop_credit            = 1'b1;
        bus.pop_receiver_in_reset = 1'b0;
        #12;
        // Reset state, with push_valid and pop_credit active
        check("rst_count",    credit_count, 0);
        check("rst_ovf",      credit_overflow, 0);
        check("rst_sir",      bus.pop_sender_in_reset, 1);
        check("rst_ready",    bus.push_ready, 0);
        check("rst_popvalid", bus.pop_valid, 0);
`ifdef CREDIT_SENDER_REG_OUT_EN
        check("rst_popdata",  bus.pop_data, 0);
`endif
        bus.push_valid = 1'b0;
        #10 rst = 1'b1;            // released at t=22, between edges
        tick();                    // first edge: sir clears, credit ignored
        check("sir_clear",    bus.pop_sender_in_reset, 0);
        check("credit_ign_sir", credit_count, 0);

        // Four consecutive credits
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("credit_up%0d", i), credit_count, i);
        end
        bus.pop_credit = 1'b0;
        #1;
        check("avail4", credit_available, 4);
        check("ready4", bus.push_ready, 1);

        // Credit into a full counter
        bus.pop_credit = 1'b1;
        #1 check("ovf_before", credit_overflow, 0);
        tick();
        bus.pop_credit = 1'b0;
        check("ovf_count", credit_count, 4);
        check("ovf_set",   credit_overflow, 1);

        // Stream 0x11..0x15 with no credits returned: only four go out
        bus.push_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.push_data = 8'(8'h11 + i);
            #1;
            check($sformatf("str_ready%0d", i), bus.push_ready, (i < 4) ? 1 : 0);
`ifndef CREDIT_SENDER_REG_OUT_EN
            check($sformatf("str_pv%0d", i), bus.pop_valid, (i < 4) ? 1 : 0);
            check($sformatf("str_pd%0d", i), bus.pop_data, 8'h11 + i);
`endif
            tick();
            check($sformatf("str_cnt%0d", i), credit_count, (i < 4) ? 3 - i : 0);
`ifdef CREDIT_SENDER_REG_OUT_EN
            check($sformatf("str_pv%0d", i), bus.pop_valid, (i < 4) ? 1 : 0);
            check($sformatf("str_pd%0d", i), bus.pop_data, (i < 4) ? 8'h11 + i : 8'h14);
`endif
        end
        bus.push_valid = 1'b0;
        #1;
        check("drain_ready", bus.push_ready, 0);
        check("ovf_sticky",  credit_overflow, 1);

        // Two credits, then a send and a credit in the same cycle
        bus.pop_credit = 1'b1;
        tick();
        tick();
        check("cnt2", credit_count, 2);
        bus.push_valid = 1'b1;
        bus.push_data  = 8'hA5;
        #1;
`ifndef CREDIT_SENDER_REG_OUT_EN
        check("both_pv", bus.pop_valid, 1);
        check("both_pd", bus.pop_data, 8'hA5);
`endif
        tick();
        bus.push_valid = 1'b0;
        check("both_cnt", credit_count, 2);
`ifdef CREDIT_SENDER_REG_OUT_EN
        check("both_pv", bus.pop_valid, 1);
        check("both_pd", bus.pop_data, 8'hA5);
`endif
        tick();                    // one more credit -> 3
        bus.pop_credit = 1'b0;
        check("cnt3", credit_count, 3);

        // Withhold changes take effect in the same cycle
        credit_withhold = 3'd3;
        #1;
        check("wh3_avail", credit_available, 0);
        check("wh3_ready", bus.push_ready, 0);
        credit_withhold = 3'd1;
        #1;
        check("wh1_avail", credit_available, 2);
        check("wh1_cnt",   credit_count, 3);
        credit_withhold = 3'd0;

        // Receiver reset: ready drops at once, count clears, credits ignored
        bus.pop_receiver_in_reset = 1'b1;
        bus.pop_credit = 1'b1;
        #1 check("rir_ready_now", bus.push_ready, 0);
        tick();
        check("rir_cnt", credit_count, 0);
        tick();
        check("rir_cnt_hold", credit_count, 0);
        bus.pop_receiver_in_reset = 1'b0;
        tick();
        tick();
        bus.pop_credit = 1'b0;
        check("rir_after_cnt", credit_count, 2);

        // rst asserted mid-stream
        bus.push_valid = 1'b1;
        bus.push_data  = 8'h5A;
        tick();
        check("mid_cnt", credit_count, 1);
        check("mid_pv",  bus.pop_valid, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_pv",    bus.pop_valid, 0);
        check("mid_rst_cnt",   credit_count, 0);
        check("mid_rst_sir",   bus.pop_sender_in_reset, 1);
        check("mid_rst_ovf",   credit_overflow, 0);
        check("mid_rst_ready", bus.push_ready, 0);
        tick();
        check("mid_rst_pv2",   bus.pop_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
